alu_exec_unit: RTL



---
 rtl/alu_pkg.sv | 69 ++++++
 rtl/alu_exec_unit_if.sv | 34 +++
 rtl/alu_mul_iter.sv | 67 ++++++
 rtl/alu_exec_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants, types and condition evaluation
// for the Y86 execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] F_ADD = 4'h0;
  localparam logic [3:0] F_SUB = 4'h1;
  localparam logic [3:0] F_AND = 4'h2;
  localparam logic [3:0] F_XOR = 4'h3;
  localparam logic [3:0] F_MUL = 4'h4;
  localparam logic [3:0] F_SHL = 4'h5;
  localparam logic [3:0] F_SAR = 4'h6;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RST = 3'b100;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  function automatic logic cond_eval(
    input logic [3:0] fn,
    input logic [2:0] cc
  );
    logic zf;
    logic sf;
    logic of;
    logic r;
    zf = cc[CC_ZF];
    sf = cc[CC_SF];
    of = cc[CC_OF];
    case (fn)
      C_ALWAYS: r = 1'b1;
      C_LE:     r = (sf ^ of) | zf;
      C_L:      r = sf ^ of;
      C_E:      r = zf;
      C_NE:     r = !zf;
      C_GE:     r = !(sf ^ of);
      C_G:      r = !(sf ^ of) & !zf;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle between decode, the
// execute ALU and the memory stage.
interface alu_exec_unit_if
  import alu_pkg::*;
#(
  parameter int DATA_WID = 64
);
  logic                in_valid;
  logic                in_ready;
  logic [3:0]          icode;
  logic [3:0]          ifun;
  logic [DATA_WID-1:0] valA;
  logic [DATA_WID-1:0] valB;
  logic [DATA_WID-1:0] valC;
  logic                out_valid;
  logic [DATA_WID-1:0] valE;
  logic                Cnd;
  logic                err;
  logic [2:0]          CC;

  modport master (
    output in_valid, icode, ifun,
    output valA, valB, valC,
    input  in_ready, out_valid,
    input  valE, Cnd, err, CC
  );

  modport slave (
    input  in_valid, icode, ifun,
    input  valA, valB, valC,
    output in_ready, out_valid,
    output valE, Cnd, err, CC
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier on operand
// magnitudes; the sign is applied to the result.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int DATA_WID = 64,
  parameter int MUL_BITS = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [DATA_WID-1:0] a,
  input  logic [DATA_WID-1:0] b,
  output logic                done,
  output logic [DATA_WID-1:0] prod
);

  localparam int N  = DATA_WID / MUL_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [DATA_WID-1:0] mcand_q;
  logic [DATA_WID-1:0] mplier_q;
  logic [DATA_WID-1:0] acc_q;
  logic [DATA_WID-1:0] acc_nxt;
  logic [CW-1:0]       cnt_q;
  logic                neg_q;
  logic                busy_q;

  always_comb begin
    acc_nxt = acc_q;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (mplier_q[i]) begin
        acc_nxt = acc_nxt + (mcand_q << i);
      end
    end
  end

  // Last chunk is folded in combinationally so the
  // product is ready on the same edge it completes.
  assign done = busy_q && (cnt_q == CW'(N - 1));
  assign prod = neg_q ? -acc_nxt : acc_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= a[DATA_WID-1] ? -a : a;
      mplier_q <= b[DATA_WID-1] ? -b : b;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= a[DATA_WID-1] ^ b[DATA_WID-1];
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << MUL_BITS;
      mplier_q <= mplier_q >> MUL_BITS;
      cnt_q    <= cnt_q + 1'b1;
      busy_q   <= !done;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Y86 execute stage: operand select, ALU, condition
// codes and Cnd, with a stalling multi-cycle multiply.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_WID = 64,
  parameter int MUL_BITS = 1
) (
  input logic CLK,
  input logic RST,
  alu_exec_unit_if.slave bus
);

  localparam int W   = DATA_WID;
  localparam int SHW = $clog2(DATA_WID);

  localparam logic [W-1:0] POS8 = W'(8);
  localparam logic [W-1:0] NEG8 = ~W'(7);

  state_t state_q;
  state_t state_d;

  logic [2:0]   cc_q;
  logic [W-1:0] vale_q;
  logic         cnd_q;
  logic         err_q;
  logic         ov_q;

  logic         accept;
  logic         is_opq;
  logic         is_cond;
  logic         sup;
  logic         bad_cond;
  logic         op_add;
  logic         op_sub;
  logic         op_and;
  logic         op_xor;
  logic         op_mul;
  logic         op_shl;
  logic         op_sar;

  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] sum;
  logic [W-1:0] diff;
  logic [W-1:0] sar_r;
  logic [W-1:0] res;
  logic         of;
  logic         cnd_v;
  logic         err_v;
  logic [SHW-1:0] shamt;

  logic         mul_done;
  logic [W-1:0] mul_prod;

  assign accept = bus.in_valid && (state_q == S_IDLE);

  assign is_opq  = bus.icode == I_OPQ;
  assign is_cond = (bus.icode == I_RRMOVQ)
                || (bus.icode == I_JXX);
  assign sup = (bus.icode >= I_RRMOVQ)
            && (bus.icode <= I_POPQ)
            && !(is_opq && (bus.ifun > F_SAR));
  assign bad_cond = is_cond && (bus.ifun > C_G);

  assign op_add = sup && (!is_opq || bus.ifun == F_ADD);
  assign op_sub = sup && is_opq && bus.ifun == F_SUB;
  assign op_and = sup && is_opq && bus.ifun == F_AND;
  assign op_xor = sup && is_opq && bus.ifun == F_XOR;
  assign op_mul = sup && is_opq && bus.ifun == F_MUL;
  assign op_shl = sup && is_opq && bus.ifun == F_SHL;
  assign op_sar = sup && is_opq && bus.ifun == F_SAR;

  always_comb begin
    alu_a = '0;
    case (bus.icode)
      I_RRMOVQ, I_OPQ:   alu_a = bus.valA;
      I_IRMOVQ, I_RMMOVQ,
      I_MRMOVQ:          alu_a = bus.valC;
      I_CALL, I_PUSHQ:   alu_a = NEG8;
      I_RET, I_POPQ:     alu_a = POS8;
      default:           alu_a = '0;
    endcase
  end

  assign alu_b = (bus.icode == I_RRMOVQ
               || bus.icode == I_IRMOVQ)
               ? '0 : bus.valB;

  assign sum   = alu_b + alu_a;
  assign diff  = alu_b - alu_a;
  assign shamt = alu_a[SHW-1:0];
  assign sar_r = $signed(alu_b) >>> shamt;

  always_comb begin
    res = '0;
    of  = 1'b0;
    unique case (1'b1)
      op_add: begin
        res = sum;
        of  = (alu_a[W-1] == alu_b[W-1])
           && (sum[W-1] != alu_a[W-1]);
      end
      op_sub: begin
        res = diff;
        of  = (alu_a[W-1] != alu_b[W-1])
           && (diff[W-1] != alu_b[W-1]);
      end
      op_and: res = alu_a & alu_b;
      op_xor: res = alu_a ^ alu_b;
      op_shl: res = alu_b << shamt;
      op_sar: res = sar_r;
      default: begin
        res = '0;
        of  = 1'b0;
      end
    endcase
  end

  // Cnd looks at the CC register as it stands now,
  // i.e. after any OPq retired on the previous edge.
  assign cnd_v = !is_cond ? 1'b1
               : bad_cond ? 1'b0
               : cond_eval(bus.ifun, cc_q);
  assign err_v = !sup || bad_cond;

  alu_mul_iter #(
    .DATA_WID (DATA_WID),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .CLK   (CLK),
    .RST   (RST),
    .start (accept && op_mul),
    .a     (alu_a),
    .b     (alu_b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (accept && op_mul) state_d = S_MUL;
      S_MUL:
        if (mul_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cc_q    <= CC_RST;
      vale_q  <= '0;
      cnd_q   <= 1'b0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ov_q    <= 1'b0;
      if (accept && !op_mul) begin
        ov_q   <= 1'b1;
        vale_q <= res;
        cnd_q  <= cnd_v;
        err_q  <= err_v;
        if (is_opq && sup) begin
          cc_q <= {res == '0, res[W-1], of};
        end
      end else if (state_q == S_MUL && mul_done) begin
        ov_q   <= 1'b1;
        vale_q <= mul_prod;
        cnd_q  <= 1'b1;
        err_q  <= 1'b0;
        cc_q   <= {mul_prod == '0, mul_prod[W-1], 1'b0};
      end
    end
  end

  assign bus.in_ready  = state_q == S_IDLE;
  assign bus.out_valid = ov_q;
  assign bus.valE      = vale_q;
  assign bus.Cnd       = cnd_q;
  assign bus.err       = err_q;
  assign bus.CC        = cc_q;

endmodule
